// File: rtl/current_adc_sampler_pkg.sv
// Shared definitions for the current-sense ADC sampler.
//   ADC_W       : width of one ADC conversion result
//   FRAME_BITS  : SCLK periods per ADC frame
//   NULL_BITS   : leading bits of a frame that must read 0
//   adc_state_t : frame sequencing states of current_adc_sampler
package current_pkg;

   localparam int ADC_W      = 12;
   localparam int FRAME_BITS = 16;
   localparam int NULL_BITS  = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      ACC
   } adc_state_t;

endpackage

// File: rtl/current_adc_sampler_spi_rx.sv
// adc_spi_rx: SCLK generator and serial receiver for one ADC frame.
// A start pulse launches FRAME_BITS SCLK periods (high CLK_DIV cycles, then
// low CLK_DIV cycles). miso is captured on the clk edge where sclk rises.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   start       : one-cycle request to begin a frame (ignored while busy)
//   miso        : serial data from the ADC
//   sclk        : serial clock to the ADC, idles low
//   done        : high on the last cycle of the final low half-period
//   data        : 12 data bits of the last frame, MSB first on the wire
//   null_err    : either leading null bit of the last frame read 1
module adc_spi_rx
   import current_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        miso,
   output logic        sclk,
   output logic        done,
   output logic [11:0] data,
   output logic        null_err
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(FRAME_BITS);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

   logic                  busy;
   logic [DIV_W-1:0]      div_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic                  phase_end;
   logic                  launch;
   logic                  capture;
   logic                  unused_tail;

   assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign launch    = start && !busy;
   // Every rising SCLK edge captures one bit: the launch edge carries bit 0,
   // later ones happen at the end of each low half-period except the last.
   assign capture   = launch || (busy && phase_end && !sclk && (bit_cnt != LAST_BIT));
   assign done      = busy && phase_end && !sclk && (bit_cnt == LAST_BIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         sclk    <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
      end else if (launch) begin
         busy    <= 1'b1;
         sclk    <= 1'b1;
         div_cnt <= '0;
         bit_cnt <= '0;
      end else if (busy) begin
         if (!phase_end) begin
            div_cnt <= div_cnt + 1'b1;
         end else begin
            div_cnt <= '0;
            if (sclk) begin
               sclk <= 1'b0;
            end else if (bit_cnt == LAST_BIT) begin
               busy <= 1'b0;
            end else begin
               sclk    <= 1'b1;
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   // Data path: no reset needed, a frame always refills all bits before done.
   always_ff @(posedge clk) begin
      if (capture) begin
         shreg <= {shreg[FRAME_BITS-2:0], miso};
      end
   end

   assign data     = shreg[FRAME_BITS-1-NULL_BITS -: ADC_W];
   assign null_err = |shreg[FRAME_BITS-1 -: NULL_BITS];
   // The two trailing bits of a frame carry no information.
   assign unused_tail = ^shreg[FRAME_BITS-NULL_BITS-ADC_W-1:0];

endmodule

// File: rtl/current_adc_sampler.sv
// current_adc_sampler: drives a 12-bit serial current-sense ADC, takes one
// sample every SAMPLE_PERIOD cycles and block-averages 2^AVG_LOG2 samples.
// Optional macro CURRENT_ADC_OFFSET_EN adds offset_cal; each sample then
// accumulates as max(raw - offset_cal, 0).
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   offset_cal     : offset subtracted from each sample (macro only)
//   adc_miso       : serial data from the ADC
//   adc_sclk       : serial clock, idles low
//   adc_cs_n       : ADC chip select, active low
//   current_b_out  : averaged current code, held between updates
//   current_valid  : one-cycle strobe when current_b_out updates
//   frame_err      : sticky null-bit error, cleared only by reset
module current_adc_sampler
   import current_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 1000,
   parameter int CS_HIGH       = 4,
   parameter int AVG_LOG2      = 2
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef CURRENT_ADC_OFFSET_EN
   input  logic [11:0] offset_cal,
`endif
   input  logic        adc_miso,
   output logic        adc_sclk,
   output logic        adc_cs_n,
   output logic [11:0] current_b_out,
   output logic        current_valid,
   output logic        frame_err
);

   localparam int N_AVG  = 1 << AVG_LOG2;
   localparam int ACC_W  = ADC_W + AVG_LOG2;
   localparam int CNT_W  = AVG_LOG2 + 1;
   localparam int TMR_W  = $clog2(SAMPLE_PERIOD);
   localparam int PH_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   generate
      if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
         $error("CLK_DIV must be in 1..255");
      end
      if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg_log2
         $error("AVG_LOG2 must be in 0..4");
      end
      if (CS_HIGH < 1) begin : g_bad_cs_high
         $error("CS_HIGH must be at least 1");
      end
      if (SAMPLE_PERIOD < 2 * CLK_DIV * 17 + CS_HIGH) begin : g_bad_period
         $error("SAMPLE_PERIOD too short for one ADC frame");
      end
   endgenerate

   adc_state_t        state;
   logic [TMR_W-1:0]  timer;
   logic [PH_W-1:0]   ph_cnt;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_next;
   logic [CNT_W-1:0]  smp_cnt;
   logic              rx_start;
   logic              rx_done;
   logic              rx_null;
   logic [11:0]       rx_data;
   logic [11:0]       sample;

`ifdef CURRENT_ADC_OFFSET_EN
   function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] raw,
                                                input logic [ADC_W-1:0] off);
      logic signed [ADC_W:0] diff;
      diff = $signed({1'b0, raw}) - $signed({1'b0, off});
      return (diff < 0) ? '0 : diff[ADC_W-1:0];
   endfunction

   assign sample = sat_sub(rx_data, offset_cal);
`else
   assign sample = rx_data;
`endif

   // Width covers N_AVG full-scale samples, so the sum never wraps.
   assign acc_next = acc + ACC_W'(sample);
   assign rx_start = (state == SETUP) && (ph_cnt == PH_W'(CLK_DIV - 1));

   adc_spi_rx #(
      .CLK_DIV (CLK_DIV)
   ) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (rx_start),
      .miso     (adc_miso),
      .sclk     (adc_sclk),
      .done     (rx_done),
      .data     (rx_data),
      .null_err (rx_null)
   );

   // Free-running period timer; a frame may start only when it reads 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (timer == TMR_W'(SAMPLE_PERIOD - 1)) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ph_cnt        <= '0;
         adc_cs_n      <= 1'b1;
         acc           <= '0;
         smp_cnt       <= '0;
         current_b_out <= '0;
         current_valid <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         current_valid <= 1'b0;
         case (state)
            // A busy FSM simply misses a timer==0 and waits for the next one.
            IDLE: begin
               if (timer == '0) begin
                  state    <= SETUP;
                  adc_cs_n <= 1'b0;
                  ph_cnt   <= '0;
               end
            end
            SETUP: begin
               if (rx_start) begin
                  state <= SHIFT;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (rx_done) begin
                  state    <= HOLD;
                  adc_cs_n <= 1'b1;
                  ph_cnt   <= '0;
                  if (rx_null) begin
                     frame_err <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (ph_cnt == PH_W'(CS_HIGH - 1)) begin
                  state <= ACC;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end
            ACC: begin
               state <= IDLE;
               if (smp_cnt == CNT_W'(N_AVG - 1)) begin
                  current_b_out <= acc_next[ADC_W-1+AVG_LOG2:AVG_LOG2];
                  current_valid <= 1'b1;
                  acc           <= '0;
                  smp_cnt       <= '0;
               end else begin
                  acc     <= acc_next;
                  smp_cnt <= smp_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               adc_cs_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_current_adc_sampler.sv
`timescale 1ns/1ps
module tb_current_adc_sampler;

   localparam int CLK_DIV       = 2;
   localparam int AVG_LOG2      = 2;
   localparam int SAMPLE_PERIOD = 100;
   localparam int CS_HIGH       = 4;
   localparam int N_AVG         = 1 << AVG_LOG2;
   localparam int NVEC          = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        adc_miso = 1'b0;
   logic        adc_sclk;
   logic        adc_cs_n;
   logic [11:0] current_b_out;
   logic        current_valid;
   logic        frame_err;
`ifdef CURRENT_ADC_OFFSET_EN
   logic [11:0] offset_cal = 12'h000;
`endif

   current_adc_sampler #(
      .CLK_DIV       (CLK_DIV),
      .SAMPLE_PERIOD (SAMPLE_PERIOD),
      .CS_HIGH       (CS_HIGH),
      .AVG_LOG2      (AVG_LOG2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef CURRENT_ADC_OFFSET_EN
      .offset_cal    (offset_cal),
`endif
      .adc_miso      (adc_miso),
      .adc_sclk      (adc_sclk),
      .adc_cs_n      (adc_cs_n),
      .current_b_out (current_b_out),
      .current_valid (current_valid),
      .frame_err     (frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mkw(input logic [1:0] nul, input logic [11:0] d,
                                       input logic [1:0] tail);
      return {nul, d, tail};
   endfunction

   function automatic logic [11:0] model_sample(input logic [11:0] d);
`ifdef CURRENT_ADC_OFFSET_EN
      return (d > offset_cal) ? (d - offset_cal) : 12'h000;
`else
      return d;
`endif
   endfunction

   // ADC model: bit 0 appears when cs_n falls, next bit on each sclk fall.
   logic [15:0] word_q[$];
   logic [15:0] cur_word = 16'h0;
   int          bit_idx = 0;
   int          rises = 0;
   logic [11:0] done_q[$];
   int          frames_done = 0;
   int          cs_fall_cnt = 0;
   time         last_fall = 0;
   bit          have_fall = 1'b0;

   always @(negedge adc_cs_n) begin
      if (rst_n) begin
         cur_word = (word_q.size() > 0) ? word_q.pop_front() : 16'h0000;
         bit_idx  = 0;
         rises    = 0;
         adc_miso = cur_word[15];
         cs_fall_cnt++;
         if (have_fall)
            check("cs_period", 32'(($time - last_fall) / 10), SAMPLE_PERIOD);
         last_fall = $time;
         have_fall = 1'b1;
      end
   end

   always @(negedge adc_sclk) begin
      if (!adc_cs_n) begin
         bit_idx++;
         if (bit_idx < 16) adc_miso = cur_word[15 - bit_idx];
      end
   end

   always @(posedge adc_sclk) rises++;

   // A frame counts only if it ran all 16 clocks and was not cut by reset.
   always @(posedge adc_cs_n) begin
      if (rst_n && rises == 16) begin
         done_q.push_back(model_sample(cur_word[13:2]));
         frames_done++;
      end
   end

   always @(negedge rst_n) begin
      done_q.delete();
      frames_done = 0;
      have_fall   = 1'b0;
   end

   // Reference average: every update must equal the truncated mean of the
   // next N_AVG completed frames.
   always @(negedge clk) begin
      if (rst_n && current_valid === 1'b1) begin
         if (done_q.size() < N_AVG) begin
            check("valid_early_frames", done_q.size(), N_AVG);
         end else begin
            int sum;
            sum = 0;
            for (int k = 0; k < N_AVG; k++) sum += int'(done_q.pop_front());
            check("model_avg", current_b_out, sum >> AVG_LOG2);
         end
      end
   end

   task automatic wait_valid(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (current_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: current_valid absent for 600 cycles", name);
      end
   endtask

   task automatic wait_cs_fall(input string name, input int target);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cs_fall_cnt >= target) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: cs_n fall count %0d never reached %0d", name, cs_fall_cnt, target);
      end
   endtask

   typedef struct packed {
      logic [3:0][15:0] w;
      logic [11:0]      exp;
   } vec_t;

   vec_t vecs[NVEC];

   initial begin
      bit ok;
      int last_cyc;
      int base;
      int sum;
      logic [11:0] d;

      // Stimulus table: four ADC words per averaging window.
      for (int j = 0; j < 4; j++) vecs[0].w[j] = mkw(2'b00, 12'hABC, 2'b00);
      vecs[0].exp = 12'hABC;
      for (int j = 0; j < 4; j++) vecs[1].w[j] = mkw(2'b00, 12'(100 + j), 2'b01);
      vecs[1].exp = 12'd101;
      for (int j = 0; j < 4; j++) vecs[2].w[j] = mkw(2'b00, 12'hFFF, 2'b11);
      vecs[2].exp = 12'hFFF;
      for (int j = 0; j < 4; j++) vecs[3].w[j] = mkw(2'b00, 12'h000, 2'b10);
      vecs[3].exp = 12'h000;
      for (int v = 4; v < NVEC; v++) begin
         sum = 0;
         for (int j = 0; j < 4; j++) begin
            d = 12'($urandom_range(0, 4095));
            vecs[v].w[j] = mkw(2'b00, d, 2'($urandom_range(0, 3)));
            sum += int'(d);
         end
         vecs[v].exp = 12'(sum / 4);
      end

      repeat (3) @(negedge clk);
      check("rst_sclk", adc_sclk, 0);
      check("rst_cs_n", adc_cs_n, 1);
      check("rst_out", current_b_out, 0);
      check("rst_valid", current_valid, 0);
      check("rst_frame_err", frame_err, 0);

      for (int v = 0; v < NVEC; v++)
         for (int j = 0; j < 4; j++) word_q.push_back(vecs[v].w[j]);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("first_frame_start", adc_cs_n, 0);

      last_cyc = 0;
      for (int v = 0; v < NVEC; v++) begin
         wait_valid("vec_valid", ok);
         if (ok) begin
            check("vec_out", current_b_out, vecs[v].exp);
            if (v > 0) check("valid_interval", cyc - last_cyc, 4 * SAMPLE_PERIOD);
            last_cyc = cyc;
            @(negedge clk);
            check("valid_one_cycle", current_valid, 0);
            check("out_held", current_b_out, vecs[v].exp);
         end
      end
      check("frame_err_clean", frame_err, 0);

      // Null bit set in frame 2 of a fresh window.
      @(negedge clk);
      rst_n = 1'b0;
      word_q.delete();
      word_q.push_back(mkw(2'b00, 12'h111, 2'b00));
      word_q.push_back(mkw(2'b01, 12'h222, 2'b00));
      word_q.push_back(mkw(2'b00, 12'h333, 2'b00));
      word_q.push_back(mkw(2'b00, 12'h444, 2'b00));
      @(negedge clk);
      rst_n = 1'b1;
      base = cs_fall_cnt;
      wait_cs_fall("null_f2", base + 2);
      check("frame_err_before", frame_err, 0);
      wait_cs_fall("null_f3", base + 3);
      check("frame_err_set", frame_err, 1);
      wait_valid("null_valid", ok);
      if (ok) check("null_avg", current_b_out, 12'h2AA);
      check("frame_err_sticky", frame_err, 1);

      // Reset during SHIFT of frame 3 of the next window.
      for (int j = 0; j < 3; j++) word_q.push_back(mkw(2'b00, 12'h500, 2'b00));
      base = cs_fall_cnt;
      wait_cs_fall("mid_f3", base + 3);
      for (int i = 0; i < 50 && adc_sclk !== 1'b1; i++) @(negedge clk);
      check("mid_sclk_high", adc_sclk, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_cs_n", adc_cs_n, 1);
      check("mid_sclk", adc_sclk, 0);
      check("mid_out", current_b_out, 0);
      check("mid_valid", current_valid, 0);
      check("mid_frame_err", frame_err, 0);
      word_q.delete();
      word_q.push_back(mkw(2'b00, 12'h010, 2'b00));
      word_q.push_back(mkw(2'b00, 12'h020, 2'b00));
      word_q.push_back(mkw(2'b00, 12'h030, 2'b00));
      word_q.push_back(mkw(2'b00, 12'h041, 2'b00));
      @(negedge clk);
      rst_n = 1'b1;
      wait_valid("post_rst_valid", ok);
      if (ok) begin
         check("post_rst_frames", frames_done, 4);
         check("post_rst_avg", current_b_out, 12'h028);
      end

`ifdef CURRENT_ADC_OFFSET_EN
      @(negedge clk);
      rst_n = 1'b0;
      offset_cal = 12'h100;
      word_q.delete();
      for (int j = 0; j < 4; j++) word_q.push_back(mkw(2'b00, 12'h080, 2'b00));
      for (int j = 0; j < 4; j++) word_q.push_back(mkw(2'b00, 12'h300, 2'b00));
      @(negedge clk);
      rst_n = 1'b1;
      wait_valid("ofs_lo_valid", ok);
      if (ok) check("ofs_saturate", current_b_out, 12'h000);
      wait_valid("ofs_hi_valid", ok);
      if (ok) check("ofs_subtract", current_b_out, 12'h200);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: run exceeded time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
